// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, FSM states, length helper.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2,
        StError  = 2'd3
    } fetch_state_e;

    // Undefined icodes report length 1 so valP still advances past the bad byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET:                    len = 4'd1;
            ICODE_CMOVXX, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:    len = 4'd2;
            ICODE_JXX, ICODE_CALL:                               len = 4'd9;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:            len = 4'd10;
            default:                                             len = 4'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/y86_ilen_decode.sv
// Combinational Y86-64 byte0/byte1 decode: length, field presence, register split, ifun legality.
module y86_ilen_decode
    import y86_pkg::*;
(
    input  logic [7:0] byte0_i,
    input  logic [7:0] byte1_i,
    output logic [3:0] len_o,
    output logic       need_regs_o,
    output logic       need_valc_o,
    output logic       ins_err_o,
    output logic [3:0] ra_o,
    output logic [3:0] rb_o
);

    logic [3:0] icode;
    logic [3:0] ifun;

    assign icode = byte0_i[7:4];
    assign ifun  = byte0_i[3:0];

    always_comb begin
        len_o       = instr_len(icode);
        need_regs_o = icode inside {ICODE_CMOVXX, ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ,
                                    ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ};
        need_valc_o = icode inside {ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_JXX,
                                    ICODE_CALL};
        ins_err_o   = 1'b0;
        if (icode > ICODE_POPQ) begin
            ins_err_o = 1'b1;
        end else if (icode == ICODE_CMOVXX || icode == ICODE_JXX) begin
            ins_err_o = (ifun > 4'd6);
        end else if (icode == ICODE_OPQ) begin
            ins_err_o = (ifun > 4'd3);
        end else begin
            ins_err_o = (ifun != 4'd0);
        end
        ra_o = need_regs_o ? byte1_i[7:4] : 4'hF;
        rb_o = need_regs_o ? byte1_i[3:0] : 4'hF;
    end

endmodule

// File: rtl/y86_imem_fetch.sv
// Byte-addressed Y86-64 instruction memory with runtime load port and registered fetch FSM.
// Optional FETCH_CNT_EN adds a saturating fetch_count output.
module y86_imem_fetch
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 200,
    parameter int unsigned ADDR_W    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              run,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    output logic              f_valid,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [2:0]        stat,
`ifdef FETCH_CNT_EN
    output logic [31:0]       fetch_count,
`endif
    output logic [1:0]        state_o
);

    localparam int unsigned    IDX_W   = $clog2(MEM_BYTES);
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_BYTES);

    logic [7:0]     mem [MEM_BYTES];
    fetch_state_e   state_q;

    logic [ADDR_W:0] pc_ext;
    logic [ADDR_W:0] byte_addr [10];
    logic [7:0]      fbyte [10];
    logic [ADDR_W:0] end_addr;
    logic [3:0]      len;
    logic            need_regs;
    logic            need_valc;
    logic            ins_err;
    logic            adr_err;
    logic [3:0]      ra_d;
    logic [3:0]      rb_d;
    logic [63:0]     valc_d;
    logic [2:0]      stat_d;
    logic            accept;

    assign pc_ext  = {1'b0, pc};
    assign accept  = (state_q == StRun) && pc_valid && !stall;
    assign state_o = state_q;

    always_ff @(posedge clock) begin
        if (state_q == StIdle && load_en && ({1'b0, load_addr} < MEM_LIM)) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Extended-width addresses keep pc near the top of the space from wrapping into memory.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            byte_addr[i] = pc_ext + (ADDR_W + 1)'(i);
            fbyte[i]     = (byte_addr[i] < MEM_LIM) ? mem[byte_addr[i][IDX_W-1:0]] : 8'h00;
        end
    end

    y86_ilen_decode u_decode (
        .byte0_i     (fbyte[0]),
        .byte1_i     (fbyte[1]),
        .len_o       (len),
        .need_regs_o (need_regs),
        .need_valc_o (need_valc),
        .ins_err_o   (ins_err),
        .ra_o        (ra_d),
        .rb_o        (rb_d)
    );

    always_comb begin
        valc_d = '0;
        for (int k = 0; k < 8; k++) begin
            if (need_valc) begin
                valc_d[8*k +: 8] = need_regs ? fbyte[k+2] : fbyte[k+1];
            end
        end
        end_addr = pc_ext + (ADDR_W + 1)'(len) - (ADDR_W + 1)'(1);
        adr_err  = (end_addr >= MEM_LIM);
        if (adr_err) begin
            stat_d = STAT_ADR;
        end else if (ins_err) begin
            stat_d = STAT_INS;
        end else if (fbyte[0] == {ICODE_HALT, 4'h0}) begin
            stat_d = STAT_HLT;
        end else begin
            stat_d = STAT_AOK;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            f_valid <= 1'b0;
            icode   <= 4'h0;
            ifun    <= 4'h0;
            rA      <= 4'hF;
            rB      <= 4'hF;
            valC    <= '0;
            valP    <= '0;
            stat    <= STAT_AOK;
        end else begin
            unique case (state_q)
                StIdle: begin
                    f_valid <= 1'b0;
                    if (run) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // A stall freezes every output, f_valid included.
                    if (!stall) begin
                        f_valid <= pc_valid;
                        if (pc_valid) begin
                            icode <= fbyte[0][7:4];
                            ifun  <= fbyte[0][3:0];
                            rA    <= ra_d;
                            rB    <= rb_d;
                            valC  <= valc_d;
                            valP  <= pc + ADDR_W'(len);
                            stat  <= stat_d;
                            if (stat_d == STAT_HLT) begin
                                state_q <= StHalted;
                            end else if (stat_d == STAT_ADR || stat_d == STAT_INS) begin
                                state_q <= StError;
                            end
                        end
                    end
                end
                StHalted, StError: begin
                    f_valid <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (accept && fetch_count != 32'hFFFF_FFFF) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_y86_imem_fetch.sv
// Self-checking bench for y86_imem_fetch: directed scenarios plus randomized fetches vs a reference model.
module tb_y86_imem_fetch;

    localparam int MB = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [63:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        run = 1'b0;
    logic        pc_valid = 1'b0;
    logic [63:0] pc = '0;
    logic        stall = 1'b0;
    logic        f_valid;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;
    logic [1:0]  state_o;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    y86_imem_fetch #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .pc_valid    (pc_valid),
        .pc          (pc),
        .stall       (stall),
        .f_valid     (f_valid),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .stat        (stat),
`ifdef FETCH_CNT_EN
        .fetch_count (fetch_count),
`endif
        .state_o     (state_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        fv;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
        logic [1:0]  st;
    } fo_t;

    logic [7:0] mm [MB];
    int checks = 0;
    int failures = 0;

    function automatic fo_t mk(input logic fv, input logic [3:0] ic, input logic [3:0] fn,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [63:0] vc, input logic [63:0] vp,
                               input logic [2:0] s, input logic [1:0] st);
        fo_t r;
        r.fv = fv; r.icode = ic; r.ifun = fn; r.ra = ra; r.rb = rb;
        r.valc = vc; r.valp = vp; r.stat = s; r.st = st;
        return r;
    endfunction

    function automatic fo_t obs();
        return mk(f_valid, icode, ifun, rA, rB, valC, valP, stat, state_o);
    endfunction

    function automatic logic [7:0] mbyte(input logic [64:0] a);
        logic [7:0] b;
        b = 8'h00;
        if (a < 65'(MB)) b = mm[a[7:0]];
        return b;
    endfunction

    // Reference: fetch result straight from the Y86-64 encoding rules over the bench's memory image.
    function automatic fo_t model_fetch(input logic [63:0] p);
        fo_t r;
        logic [64:0] pe;
        logic [7:0]  b0, b1;
        int          len, off;
        logic        ok_fun;
        pe = {1'b0, p};
        b0 = mbyte(pe);
        b1 = mbyte(pe + 65'd1);
        r.fv = 1'b1;
        r.icode = b0[7:4];
        r.ifun = b0[3:0];
        case (b0[7:4])
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        if (b0[7:4] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
            r.ra = b1[7:4];
            r.rb = b1[3:0];
        end else begin
            r.ra = 4'hF;
            r.rb = 4'hF;
        end
        off = 0;
        if (b0[7:4] inside {4'h3, 4'h4, 4'h5}) off = 2;
        if (b0[7:4] inside {4'h7, 4'h8}) off = 1;
        r.valc = '0;
        if (off != 0) begin
            for (int k = 0; k < 8; k++) r.valc[8*k +: 8] = mbyte(pe + 65'(off + k));
        end
        r.valp = p + 64'(len);
        if (b0[7:4] == 4'h2 || b0[7:4] == 4'h7) ok_fun = (b0[3:0] <= 4'd6);
        else if (b0[7:4] == 4'h6)               ok_fun = (b0[3:0] <= 4'd3);
        else                                    ok_fun = (b0[3:0] == 4'd0);
        if (pe + 65'(len) - 65'd1 >= 65'(MB))   r.stat = 3'd3;
        else if (b0[7:4] > 4'hB || !ok_fun)     r.stat = 3'd4;
        else if (b0 == 8'h00)                   r.stat = 3'd2;
        else                                    r.stat = 3'd1;
        r.st = (r.stat == 3'd1) ? 2'd1 : (r.stat == 3'd2) ? 2'd2 : 2'd3;
        return r;
    endfunction

    // Undefined icodes leave operand fields unconstrained.
    function automatic fo_t mask_for(input fo_t e);
        fo_t m;
        m = '1;
        if (e.icode > 4'hB) begin
            m.ra = '0; m.rb = '0; m.valc = '0; m.valp = '0;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [63:0] a, input logic [7:0] d, input logic with_run);
        load_en = 1'b1; load_addr = a; load_data = d; run = with_run;
        tick();
        load_en = 1'b0; run = 1'b0;
        if (a < 64'(MB)) mm[a[7:0]] = d;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] p);
        pc_valid = 1'b1; pc = p;
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic load_prog1();
        logic [7:0] prog [10];
        prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) load(64'(i), prog[i], 1'b0);
    endtask

    task automatic test_reset();
        fo_t o, e;
        do_reset();
        o = obs();
        e = mk(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 2'd0);
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, e); end
    endtask

    task automatic test_irmovq();
        fo_t o, e;
        do_reset();
        load_prog1();
        start_run();
        fetch(64'd0);
        o = obs();
        e = mk(1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 3'd1, 2'd1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL irmovq_fetch got=%h exp=%h", o, e); end
        tick();
        o = obs();
        e.fv = 1'b0;
        checks++;
        if (o !== e) begin failures++; $display("FAIL irmovq_idle_cycle got=%h exp=%h", o, e); end
    endtask

    task automatic test_halt();
        fo_t o, e;
        do_reset();
        load(64'd0, 8'h60, 1'b0);
        load(64'd1, 8'h23, 1'b0);
        load(64'd2, 8'h00, 1'b0);
        start_run();
        fetch(64'd0);
        o = obs();
        e = mk(1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 3'd1, 2'd1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL opq_fetch got=%h exp=%h", o, e); end
        fetch(64'd2);
        o = obs();
        e = mk(1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd3, 3'd2, 2'd2);
        checks++;
        if (o !== e) begin failures++; $display("FAIL halt_fetch got=%h exp=%h", o, e); end
        fetch(64'd0);
        o = obs();
        e.fv = 1'b0;
        checks++;
        if (o !== e) begin failures++; $display("FAIL halted_ignores got=%h exp=%h", o, e); end
        load(64'd5, 8'h77, 1'b0);
        mm[5] = 8'hFF;
        load(64'd5, 8'hFF, 1'b0);
    endtask

    task automatic test_adr();
        fo_t o, e;
        do_reset();
        load(64'd195, 8'h30, 1'b0);
        start_run();
        fetch(64'd195);
        o = obs();
        e = model_fetch(64'd195);
        checks++;
        if (o.stat !== 3'd3 || o.st !== 2'd3) begin
            failures++; $display("FAIL adr_stat got=%0d/%0d exp=3/3", o.stat, o.st);
        end
        checks++;
        if (o !== e) begin failures++; $display("FAIL adr_fields got=%h exp=%h", o, e); end
        do_reset();
        start_run();
        fetch(64'hFFFF_FFFF_FFFF_FFFF);
        o = obs();
        e = mk(1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd3, 2'd3);
        checks++;
        if (o !== e) begin failures++; $display("FAIL adr_nowrap got=%h exp=%h", o, e); end
    endtask

    task automatic test_ins();
        fo_t o, e, m;
        do_reset();
        load(64'd0, 8'hC0, 1'b0);
        start_run();
        fetch(64'd0);
        o = obs();
        e = mk(1'b1, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 3'd4, 2'd3);
        m = mask_for(e);
        checks++;
        if ((o & m) !== (e & m)) begin failures++; $display("FAIL ins_icode got=%h exp=%h", o, e); end
        do_reset();
        load(64'd0, 8'h27, 1'b0);
        start_run();
        fetch(64'd0);
        o = obs();
        e = model_fetch(64'd0);
        checks++;
        if (o !== e || o.stat !== 3'd4) begin
            failures++; $display("FAIL ins_ifun got=%h exp=%h", o, e);
        end
        do_reset();
        load(64'd0, 8'h26, 1'b0);
        load(64'd1, 8'h45, 1'b0);
        start_run();
        fetch(64'd0);
        o = obs();
        e = mk(1'b1, 4'h2, 4'h6, 4'h4, 4'h5, 64'd0, 64'd2, 3'd1, 2'd1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL cmov_legal got=%h exp=%h", o, e); end
    endtask

    task automatic test_stall();
        fo_t o, e;
        do_reset();
        load_prog1();
        start_run();
        fetch(64'd0);
        e = model_fetch(64'd0);
        stall = 1'b1;
        pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 64'($urandom_range(1, MB - 1));
            tick();
            o = obs();
            checks++;
            if (o !== e) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, o, e); end
        end
        stall = 1'b0;
        pc_valid = 1'b0;
        load_en = 1'b1; load_addr = 64'd0; load_data = 8'h10;
        tick();
        load_en = 1'b0;
        fetch(64'd0);
        o = obs();
        checks++;
        if (o !== e) begin failures++; $display("FAIL load_in_run got=%h exp=%h", o, e); end
    endtask

    task automatic test_reset_midrun();
        fo_t o, e;
        do_reset();
        o = obs();
        e = mk(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 2'd0);
        checks++;
        if (o !== e) begin failures++; $display("FAIL midrun_reset got=%h exp=%h", o, e); end
`ifdef FETCH_CNT_EN
        checks++;
        if (fetch_count !== 32'd0) begin
            failures++; $display("FAIL count_reset got=%0d exp=0", fetch_count);
        end
`endif
        start_run();
        fetch(64'd0);
        o = obs();
        e = mk(1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 3'd1, 2'd1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL rerun_noreload got=%h exp=%h", o, e); end
`ifdef FETCH_CNT_EN
        checks++;
        if (fetch_count !== 32'd1) begin
            failures++; $display("FAIL count_one got=%0d exp=1", fetch_count);
        end
`endif
    endtask

    task automatic test_random();
        fo_t o, e, m, idle;
        logic [63:0] p;
        logic [7:0]  b0;
        int          nst;
        for (int it = 0; it < 30; it++) begin
            do_reset();
            p = (it % 3 == 0) ? 64'($urandom_range(MB - 12, MB - 1)) : 64'($urandom_range(0, MB - 1));
            b0 = {4'($urandom_range(0, 12)), 4'($urandom_range(0, 7))};
            if (it % 2 == 0) begin
                load(p, b0, 1'b1);
            end else begin
                load(p, b0, 1'b0);
                start_run();
            end
            nst = $urandom_range(0, 2);
            idle = mk(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 2'd1);
            stall = 1'b1;
            pc_valid = 1'b1;
            for (int s = 0; s < nst; s++) begin
                pc = p;
                tick();
                o = obs();
                checks++;
                if (o !== idle) begin failures++; $display("FAIL rnd_stall it=%0d got=%h exp=%h", it, o, idle); end
            end
            stall = 1'b0;
            pc_valid = 1'b0;
            fetch(p);
            o = obs();
            e = model_fetch(p);
            m = mask_for(e);
            checks++;
            if ((o & m) !== (e & m)) begin
                failures++; $display("FAIL rnd_fetch it=%0d pc=%0d got=%h exp=%h", it, p, o, e);
            end
            if (e.stat == 3'd1) begin
                p = e.valp;
                fetch(p);
                o = obs();
                e = model_fetch(p);
                m = mask_for(e);
                checks++;
                if ((o & m) !== (e & m)) begin
                    failures++; $display("FAIL rnd_next it=%0d pc=%0d got=%h exp=%h", it, p, o, e);
                end
            end
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < MB; a++) load(64'(a), 8'($urandom), 1'b0);
        test_reset();
        test_irmovq();
        test_halt();
        test_adr();
        test_ins();
        test_stall();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
